// File: rtl/intr_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the interrupt controller.
// Register offsets are byte offsets inside the FFFF_3xxx peripheral window.
package intr_ctrl_pkg;

    localparam int NSRC_MAX = 16;

    localparam logic [11:0] INTC_PENDING   = 12'h000;
    localparam logic [11:0] INTC_ENABLE    = 12'h004;
    localparam logic [11:0] INTC_CLAIM     = 12'h008;
    localparam logic [11:0] INTC_EOI       = 12'h00C;
    localparam logic [11:0] INTC_INSERVICE = 12'h010;
    localparam logic [11:0] INTC_MODE      = 12'h014;

    localparam logic [31:0] CLAIM_VALID = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } intc_state_e;

    function automatic logic [31:0] claim_word(
        input logic [3:0] idx
    );
        return CLAIM_VALID | {28'd0, idx};
    endfunction

endpackage

// File: rtl/intr_src_cond.sv
// Per-source conditioning: two-stage sampler, level/falling-edge capture
// and the PENDING bit, cleared by a claim only while in edge mode.
module intr_src_cond
    import intr_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic src_n,
    input  logic edge_mode,
    input  logic claim_clr,
    output logic pending
);

    logic src_q;
    logic src_d;
    logic fall;

    assign fall = src_q & ~src_d;

    // A fresh falling edge wins over a claim in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q   <= 1'b0;
            src_d   <= 1'b0;
            pending <= 1'b0;
        end else begin
            src_q <= ~src_n;
            src_d <= src_q;
            if (!edge_mode) begin
                pending <= src_q;
            end else if (fall) begin
                pending <= 1'b1;
            end else if (claim_clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller: enable/mode/in-service registers,
// fixed-priority claim, EOI retire and the single registered IRQ line.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int NSRC = 4
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            CS_N,
    input  logic            RD_N,
    input  logic            WR_N,
    input  logic [11:0]     Addr,
    input  logic [31:0]     DataIn,
    output logic [31:0]     DataOut,
    input  logic [NSRC-1:0] IntrSrc_N,
    output logic            IRQ
);

    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] enable;
    logic [NSRC-1:0] mode;
    logic [NSRC-1:0] inservice;
    logic [NSRC-1:0] inservice_nxt;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] claim_vec;
    logic [NSRC-1:0] eoi_vec;

    intc_state_e state;
    intc_state_e state_nxt;

    logic [3:0]  win_idx;
    logic        has_win;
    logic        rd_en;
    logic        wr_en;
    logic        claim_ok;
    logic        eoi_wr;
    logic        eoi_ok;
    logic        irq_q;
    logic [31:0] rdata;
    logic        unused_data;

    assign rd_en  = ~CS_N & ~RD_N;
    assign wr_en  = ~CS_N & ~WR_N;
    assign eoi_wr = wr_en && (Addr == INTC_EOI);

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        intr_src_cond u_cond (
            .clk       (clk),
            .reset     (reset),
            .src_n     (IntrSrc_N[i]),
            .edge_mode (mode[i]),
            .claim_clr (claim_vec[i]),
            .pending   (pending[i])
        );
    end

    assign eligible = pending & enable & ~inservice;
    assign has_win  = |eligible;

    // Walk from the top so the lowest set index is left standing.
    always_comb begin
        win_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx = 4'(i);
            end
        end
    end

    assign claim_ok = rd_en && (Addr == INTC_CLAIM)
                      && (state == ASSERT) && has_win;

    always_comb begin
        claim_vec = '0;
        eoi_vec   = '0;
        for (int i = 0; i < NSRC; i++) begin
            claim_vec[i] = claim_ok && (win_idx == 4'(i));
            eoi_vec[i]   = eoi_wr && (DataIn[3:0] == 4'(i))
                           && inservice[i];
        end
    end

    assign eoi_ok        = |eoi_vec;
    assign inservice_nxt = (inservice | claim_vec) & ~eoi_vec;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (has_win) begin
                    state_nxt = ASSERT;
                end
            end
            ASSERT: begin
                if (claim_ok) begin
                    state_nxt = SERVICE;
                end else if (!has_win) begin
                    state_nxt = IDLE;
                end
            end
            SERVICE: begin
                if (eoi_ok && (inservice_nxt == '0)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            irq_q     <= 1'b0;
            enable    <= '0;
            mode      <= '0;
            inservice <= '0;
        end else begin
            state     <= state_nxt;
            irq_q     <= (state_nxt == ASSERT);
            inservice <= inservice_nxt;
            if (wr_en && (Addr == INTC_ENABLE)) begin
                enable <= DataIn[NSRC-1:0];
            end
            if (wr_en && (Addr == INTC_MODE)) begin
                mode <= DataIn[NSRC-1:0];
            end
        end
    end

    assign IRQ = irq_q;

    always_comb begin
        rdata = '0;
        case (Addr)
            INTC_PENDING:   rdata[NSRC-1:0] = pending;
            INTC_ENABLE:    rdata[NSRC-1:0] = enable;
            INTC_CLAIM: begin
                if ((state == ASSERT) && has_win) begin
                    rdata = claim_word(win_idx);
                end
            end
            INTC_INSERVICE: rdata[NSRC-1:0] = inservice;
            INTC_MODE:      rdata[NSRC-1:0] = mode;
            default:        rdata = '0;
        endcase
    end

    assign DataOut = rd_en ? rdata : '0;

    // Upper write-data bits are architecturally ignored.
    assign unused_data = ^DataIn;

endmodule
